systemizer_ctrl: RTL and testbench
==================================

# systemizer_ctrl

Sequencing controller for the `systemizer` matrix-systematization core. It accepts a matrix from a byte-wide host stream into a shared 1R1W block memory, then runs the left and right systemization phases. It hands the memory ports to the core while the core runs, and streams the result matrix back to the host. The block sits between the top-level pin logic and `systemizer`; it also owns memory-port arbitration and fault/timeout reporting.

## Interface
Parameters:
- `L`, default 8: matrix rows.
- `K`, default 16: matrix columns.
- `M`, default 3: field size; element width `EW = CLOG2(M)`, so 2.
- `BLOCK`, default 4: elements per memory word; word width `WW = BLOCK*EW`, so 8.
- `TIMEOUT`, default 4096: maximum cycles per phase before abort.
- Derived: `DEPTH = L*K/BLOCK` (32), `AW = CLOG2(DEPTH)` (5).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_start`  in  1  one-cycle pulse; begins a job; ignored unless idle.
- `cmd_abort`  in  1  synchronous abort to IDLE from any state.
- `cfg_left_op`, `cfg_right_op`  in  2 each  op codes, latched at accepted `cmd_start`.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in WW: host load stream.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out WW: host result stream.
- `busy`  out  1  high when not IDLE.
- `status_success`, `status_fail`, `status_timeout`  out  1 each  sticky; cleared by accepted `cmd_start`.
- `sys_start`, `sys_start_right`  out  1 each  one-cycle phase-start pulses to the core.
- `sys_left_op`, `sys_right_op`  out  2 each  latched op codes.
- `sys_done`, `sys_fail`, `sys_success`  in  1 each  core completion; `sys_fail`/`sys_success` are valid while `sys_done` is high.
- Core memory port:
  - `sys_rd_en` in 1, `sys_rd_addr` in AW, `sys_rd_data` out WW.
  - `sys_wr_en` in 1, `sys_wr_addr` in AW, `sys_wr_data` in WW.
- Memory port:
  - `mem_rd_en` out 1, `mem_rd_addr` out AW, `mem_rd_data` in WW.
  - `mem_wr_en` out 1, `mem_wr_addr` out AW, `mem_wr_data` out WW.
- Memory behaviour: read latency is 1 cycle. `mem_rd_data` holds its value while `mem_rd_en` is low.

## Operation
- States are IDLE, LOAD, RUN_L, RUN_R, UNLOAD.
- IDLE:
  - On `cmd_start`: clear status flags, latch op codes, clear address pointer, go to LOAD.
- LOAD:
  - `in_ready` = 1.
  - Each `in_valid & in_ready` writes `in_data` to `mem_wr_addr` = ptr, then ptr++.
  - After word DEPTH-1 is written, go to RUN_L.
- RUN_L:
  - `sys_start` pulses on the first cycle of the state only.
  - The memory ports are muxed straight from the `sys_*` signals. `sys_rd_data` = `mem_rd_data`.
  - On `sys_done`:
    - If `sys_fail` is set, assert `status_fail` and go to IDLE. `sys_fail` wins if both flags are asserted.
    - Otherwise go to RUN_R.
- RUN_R:
  - Same as RUN_L, with `sys_start_right` as the pulse.
  - On `sys_done` with `sys_success`, go to UNLOAD.
  - On `sys_done` with `sys_fail`, set `status_fail` and go to IDLE.
- UNLOAD:
  - Issue a read of ptr when `ptr < DEPTH` and (`!out_valid` | `out_ready`); ptr++.
  - `out_valid` is set the cycle after an issued read. It is cleared on a handshake that has no new read issued.
  - `out_data` = `mem_rd_data`.
  - After the last handshake (word DEPTH-1), set `status_success` and go to IDLE.
- Watchdog:
  - Counts cycles in RUN_L/RUN_R and resets on entry to each state.
  - If the count reaches TIMEOUT-1 without `sys_done`, set `status_timeout` and `status_fail`, and go to IDLE.
- Core memory gating: outside RUN states, `sys_rd_en`/`sys_wr_en` are ignored and `sys_rd_data` = 0.
- `cmd_abort`:
  - Next state is IDLE, all strobes drop, ptr is cleared.
  - Status flags are unchanged.
  - `cmd_abort` has priority over every other event in the same cycle.

## Timing
- Reset values: every output is 0, state is IDLE, ptr is 0, op-code registers are 0.
- Latency:
  - `cmd_start` → `in_ready` high: 1 cycle.
  - Last load write → `sys_start` high: 1 cycle.
  - `sys_done` → `sys_start_right`: 1 cycle.
  - RUN_R `sys_done` → first `mem_rd_en`: 1 cycle; first `out_valid` 1 cycle later.
- Throughput: unload runs at 1 word/cycle while `out_ready` is held high. Stalls are lossless under any `out_ready` pattern.
- All `mem_*` outputs are combinational from state and the registered pointer. `busy` and `status_*` are registered.

## Structure
- Shared package/header `systemizer_pkg`:
  - State encoding.
  - Op-code constants.
  - Derived widths `EW`, `WW`, `DEPTH`, `AW` via the `CLOG2` macro.
- The `systemizer` core and the top-level wrapper include the same package.
- One sub-module, `systemizer_wdog`: loadable counter with `clear`, `run`, and `expired` outputs, parameterized by TIMEOUT.

## Test plan
- Full pass: load words 0x00..0x1F; core model returns done+success for both phases. Required: `sys_start` and `sys_start_right` exactly once each; 32 words unloaded in order; `status_success`=1; `busy`=0.
- Left fail: the model asserts `sys_done`+`sys_fail` 10 cycles after `sys_start`. Required: `status_fail`=1, no `sys_start_right`, IDLE the next cycle.
- Timeout with TIMEOUT=16: the core never asserts done. Required: `status_timeout`=`status_fail`=1 exactly 16 cycles after `sys_start`.
- Backpressure: toggle `out_ready` 1/0 every cycle during unload. Required: 32 words with no duplicates or drops; `out_data` is stable while `out_valid & !out_ready`.
- Abort mid-LOAD after 7 words, then a new `cmd_start`. Required: abort reaches IDLE in 1 cycle; the new job loads from address 0.
- `cmd_start` while busy in RUN_L is ignored; op codes keep their latched values (e.g. left=2'b01, right=2'b10).

Source files
------------

// File: rtl/systemizer_pkg.sv
// systemizer_pkg: definitions shared by the systemizer core, its sequencing
// controller and the watchdog. It holds the controller state encoding, the
// op-code constants and the default geometry, with derived widths.
//   EW    element width (bits per field element)
//   WW    memory word width (BLOCK elements per word)
//   DEPTH words per matrix
//   AW    memory address width
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package systemizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN_L  = 3'd2,
        ST_RUN_R  = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_A    = 2'd1;
    localparam logic [1:0] OP_B    = 2'd2;
    localparam logic [1:0] OP_AB   = 2'd3;

    localparam int DEF_L     = 8;
    localparam int DEF_K     = 16;
    localparam int DEF_M     = 3;
    localparam int DEF_BLOCK = 4;

    localparam int EW    = `CLOG2(DEF_M);
    localparam int WW    = DEF_BLOCK * EW;
    localparam int DEPTH = DEF_L * DEF_K / DEF_BLOCK;
    localparam int AW    = `CLOG2(DEPTH);

endpackage

// File: rtl/systemizer_wdog.sv
// systemizer_wdog: phase watchdog. It is a down-counter that is reloaded
// with TIMEOUT-1 while clear is high and decrements while run is high.
// expired is high on a run cycle where the counter has reached zero. That
// is the TIMEOUT-th cycle counted since the last clear.
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       reload the counter (has priority over run)
//   run         count this cycle
//   expired     terminal count reached while running
module systemizer_wdog
    import systemizer_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= TC_LOAD;
        end else if (clear) begin
            cnt <= TC_LOAD;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/systemizer_ctrl.sv
// systemizer_ctrl: sequencing controller for the systemizer core.
// It loads a matrix from the host stream into the shared 1R1W memory, runs
// the left and right phases on the core with the memory ports handed over,
// and then streams the result back to the host.
//   clk, rst_n                   clock and asynchronous active-low reset
//   cmd_start, cmd_abort         job start (honoured in IDLE) and abort
//   cfg_left_op, cfg_right_op    op codes, latched on an accepted start
//   in_valid/in_ready/in_data    host load stream
//   out_valid/out_ready/out_data host result stream
//   busy, status_*               registered job status; status bits are sticky
//   sys_*                        core control and core memory port
//   mem_*                        shared memory port (1-cycle read latency)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cmd_start
// ST_LOAD   | host words written to memory at ptr, 0..DEPTH-1
// ST_RUN_L  | core owns memory, left phase, watchdog running
// ST_RUN_R  | core owns memory, right phase, watchdog running
// ST_UNLOAD | memory read at ptr and streamed to the host
module systemizer_ctrl
    import systemizer_pkg::*;
#(
    parameter  int L       = DEF_L,
    parameter  int K       = DEF_K,
    parameter  int M       = DEF_M,
    parameter  int BLOCK   = DEF_BLOCK,
    parameter  int TIMEOUT = 4096,
    localparam int EW      = `CLOG2(M),
    localparam int WW      = BLOCK * EW,
    localparam int DEPTH   = L * K / BLOCK,
    localparam int AW      = `CLOG2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_start,
    input  logic          cmd_abort,
    input  logic [1:0]    cfg_left_op,
    input  logic [1:0]    cfg_right_op,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_data,
    output logic          busy,
    output logic          status_success,
    output logic          status_fail,
    output logic          status_timeout,
    output logic          sys_start,
    output logic          sys_start_right,
    output logic [1:0]    sys_left_op,
    output logic [1:0]    sys_right_op,
    input  logic          sys_done,
    input  logic          sys_fail,
    input  logic          sys_success,
    input  logic          sys_rd_en,
    input  logic [AW-1:0] sys_rd_addr,
    output logic [WW-1:0] sys_rd_data,
    input  logic          sys_wr_en,
    input  logic [AW-1:0] sys_wr_addr,
    input  logic [WW-1:0] sys_wr_data,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [WW-1:0] mem_rd_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [WW-1:0] mem_wr_data
);

    // One extra bit so the unload pointer can reach DEPTH ("all reads issued").
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_END  = PW'(DEPTH);

    state_t        state;
    logic [PW-1:0] ptr;
    logic          in_run;
    logic          load_wr;
    logic          rd_issue;
    logic          unload_done;
    logic          wd_expired;

    assign in_run      = (state == ST_RUN_L) || (state == ST_RUN_R);
    assign load_wr     = (state == ST_LOAD) && in_valid && in_ready;
    assign rd_issue    = (state == ST_UNLOAD) && (ptr < PTR_END) && (!out_valid || out_ready);
    assign unload_done = (state == ST_UNLOAD) && (ptr == PTR_END) && out_valid && out_ready;

    // sys_done reloads the watchdog, so RUN_R starts with a full budget.
    systemizer_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_run || sys_done),
        .run     (in_run),
        .expired (wd_expired)
    );

    assign mem_rd_en   = in_run ? sys_rd_en   : rd_issue;
    assign mem_rd_addr = in_run ? sys_rd_addr : ptr[AW-1:0];
    assign mem_wr_en   = in_run ? sys_wr_en   : load_wr;
    assign mem_wr_addr = in_run ? sys_wr_addr : ptr[AW-1:0];
    assign mem_wr_data = in_run ? sys_wr_data : ((state == ST_LOAD) ? in_data : '0);
    assign sys_rd_data = in_run ? mem_rd_data : '0;
    // No read is issued while a word is stalled, so mem_rd_data holds it.
    assign out_data    = out_valid ? mem_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            in_ready        <= 1'b0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            status_success  <= 1'b0;
            status_fail     <= 1'b0;
            status_timeout  <= 1'b0;
            sys_start       <= 1'b0;
            sys_start_right <= 1'b0;
            sys_left_op     <= '0;
            sys_right_op    <= '0;
        end else begin
            sys_start       <= 1'b0;
            sys_start_right <= 1'b0;
            if (cmd_abort) begin
                state     <= ST_IDLE;
                ptr       <= '0;
                in_ready  <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_start) begin
                            status_success <= 1'b0;
                            status_fail    <= 1'b0;
                            status_timeout <= 1'b0;
                            sys_left_op    <= cfg_left_op;
                            sys_right_op   <= cfg_right_op;
                            ptr            <= '0;
                            in_ready       <= 1'b1;
                            busy           <= 1'b1;
                            state          <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (load_wr) begin
                            if (ptr == PTR_LAST) begin
                                ptr       <= '0;
                                in_ready  <= 1'b0;
                                sys_start <= 1'b1;
                                state     <= ST_RUN_L;
                            end else begin
                                ptr <= ptr + PW'(1);
                            end
                        end
                    end
                    ST_RUN_L: begin
                        if (sys_done) begin
                            if (sys_fail) begin
                                status_fail <= 1'b1;
                                busy        <= 1'b0;
                                state       <= ST_IDLE;
                            end else begin
                                sys_start_right <= 1'b1;
                                state           <= ST_RUN_R;
                            end
                        end else if (wd_expired) begin
                            status_timeout <= 1'b1;
                            status_fail    <= 1'b1;
                            busy           <= 1'b0;
                            state          <= ST_IDLE;
                        end
                    end
                    ST_RUN_R: begin
                        if (sys_done) begin
                            // A completion that reports neither flag is treated as a failure.
                            if (sys_success && !sys_fail) begin
                                ptr   <= '0;
                                state <= ST_UNLOAD;
                            end else begin
                                status_fail <= 1'b1;
                                busy        <= 1'b0;
                                state       <= ST_IDLE;
                            end
                        end else if (wd_expired) begin
                            status_timeout <= 1'b1;
                            status_fail    <= 1'b1;
                            busy           <= 1'b0;
                            state          <= ST_IDLE;
                        end
                    end
                    ST_UNLOAD: begin
                        if (rd_issue) begin
                            ptr       <= ptr + PW'(1);
                            out_valid <= 1'b1;
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                        if (unload_done) begin
                            status_success <= 1'b1;
                            busy           <= 1'b0;
                            ptr            <= '0;
                            state          <= ST_IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systemizer_ctrl.sv
// tb_systemizer_ctrl: directed bench for systemizer_ctrl, with a 1-cycle-latency
// memory model and an inline core model. Inputs are driven 1 ns after the rising
// edge, and outputs are sampled there too.
module tb_systemizer_ctrl;

    localparam int WW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_start = 1'b0, cmd_abort = 1'b0;
    logic [1:0]    cfg_left_op = 2'b00, cfg_right_op = 2'b00;
    logic          in_valid = 1'b0, in_ready;
    logic [WW-1:0] in_data = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic          busy, status_success, status_fail, status_timeout;
    logic          sys_start, sys_start_right;
    logic [1:0]    sys_left_op, sys_right_op;
    logic          sys_done = 1'b0, sys_fail = 1'b0, sys_success = 1'b0;
    logic          sys_rd_en = 1'b0, sys_wr_en = 1'b0;
    logic [AW-1:0] sys_rd_addr = '0, sys_wr_addr = '0;
    logic [WW-1:0] sys_rd_data, sys_wr_data = '0;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [WW-1:0] mem_rd_data = '0, mem_wr_data;

    logic [WW-1:0] mem     [DEPTH];
    logic [WW-1:0] exp_mem [DEPTH];

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_right = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    systemizer_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_left_op(cfg_left_op), .cfg_right_op(cfg_right_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .status_success(status_success), .status_fail(status_fail),
        .status_timeout(status_timeout),
        .sys_start(sys_start), .sys_start_right(sys_start_right),
        .sys_left_op(sys_left_op), .sys_right_op(sys_right_op),
        .sys_done(sys_done), .sys_fail(sys_fail), .sys_success(sys_success),
        .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_rd_data(sys_rd_data),
        .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_wr_data(sys_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (sys_start) n_start++;
        if (sys_start_right) n_right++;
    endtask

    task automatic do_start(input logic [1:0] lop, input logic [1:0] rop);
        cfg_left_op  = lop;
        cfg_right_op = rop;
        cmd_start    = 1'b1;
        tick();
        cmd_start    = 1'b0;
    endtask

    task automatic do_load(input int n, input logic [WW-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b1;
            in_data    = base + WW'(i);
            exp_mem[i] = base + WW'(i);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_abort();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
    endtask

    task automatic run_unload(input bit toggle, output int cycles);
        int got;
        logic held;
        logic [WW-1:0] held_data;
        got = 0;
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            out_ready = toggle ? ~k[0] : 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (got >= DEPTH) begin
                    failures++;
                    $display("FAIL unload_extra_word: got %h beyond word %0d", out_data, DEPTH - 1);
                end else if (out_data !== exp_mem[got]) begin
                    failures++;
                    $display("FAIL unload_word[%0d]: got %h expected %h", got, out_data, exp_mem[got]);
                end
                got++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            tick();
            cycles++;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%b data=%h expected valid=1 data=%h",
                             out_valid, out_data, held_data);
                end
            end
            if (!busy) break;
        end
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || got != DEPTH) begin
            failures++;
            $display("FAIL unload_count: busy=%b words=%0d expected busy=0 words=%0d", busy, got, DEPTH);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        checks++;
        if ({busy, in_ready, out_valid, status_success, status_fail, status_timeout,
             sys_start, sys_start_right, sys_left_op, sys_right_op, mem_rd_en, mem_wr_en,
             out_data, sys_rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b in_ready=%b out_valid=%b status=%b%b%b ops=%b/%b",
                     busy, in_ready, out_valid, status_success, status_fail, status_timeout,
                     sys_left_op, sys_right_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sys_rd_en = 1'b1;
        sys_wr_en = 1'b1;
        sys_wr_addr = 5'd3;
        sys_wr_data = 8'hEE;
        #1;
        checks++;
        if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_gating: mem_rd_en=%b mem_wr_en=%b expected 0/0", mem_rd_en, mem_wr_en);
        end
        sys_rd_en = 1'b0;
        sys_wr_en = 1'b0;
        sys_wr_data = '0;
        sys_wr_addr = '0;
    endtask

    task automatic test_full_pass();
        int cycles;
        n_start = 0;
        n_right = 0;
        do_start(2'b10, 2'b01);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || sys_left_op !== 2'b10 || sys_right_op !== 2'b01) begin
            failures++;
            $display("FAIL start_accept: in_ready=%b busy=%b ops=%b/%b expected 1/1 10/01",
                     in_ready, busy, sys_left_op, sys_right_op);
        end
        do_load(DEPTH, 8'h00);
        checks++;
        if (sys_start !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_to_run: sys_start=%b in_ready=%b expected 1/0", sys_start, in_ready);
        end
        // Core writes word 5 and reads word 3 through the controller.
        sys_wr_en = 1'b1; sys_wr_addr = 5'd5; sys_wr_data = 8'hA5; exp_mem[5] = 8'hA5;
        sys_rd_en = 1'b1; sys_rd_addr = 5'd3;
        tick();
        sys_wr_en = 1'b0; sys_rd_en = 1'b0;
        checks++;
        if (sys_rd_data !== 8'h03) begin
            failures++;
            $display("FAIL core_read: got %h expected 03", sys_rd_data);
        end
        sys_done = 1'b1; sys_success = 1'b1;
        tick();
        sys_done = 1'b0; sys_success = 1'b0;
        checks++;
        if (sys_start_right !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL right_start: sys_start_right=%b busy=%b expected 1/1", sys_start_right, busy);
        end
        tick();
        sys_done = 1'b1; sys_success = 1'b1;
        tick();
        sys_done = 1'b0; sys_success = 1'b0;
        #1;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 5'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL unload_first_read: rd_en=%b addr=%0d out_valid=%b expected 1/0/0",
                     mem_rd_en, mem_rd_addr, out_valid);
        end
        run_unload(1'b0, cycles);
        checks++;
        if (cycles != 33) begin
            failures++;
            $display("FAIL unload_throughput: cycles=%0d expected 33", cycles);
        end
        checks++;
        if (status_success !== 1'b1 || status_fail !== 1'b0 || busy !== 1'b0 || n_start != 1 || n_right != 1) begin
            failures++;
            $display("FAIL full_pass_end: success=%b fail=%b busy=%b starts=%0d rights=%0d expected 1/0/0/1/1",
                     status_success, status_fail, busy, n_start, n_right);
        end
    endtask

    task automatic test_left_fail();
        n_start = 0;
        n_right = 0;
        do_start(2'b01, 2'b01);
        checks++;
        if (status_success !== 1'b0) begin
            failures++;
            $display("FAIL status_clear: status_success=%b expected 0", status_success);
        end
        do_load(DEPTH, 8'h20);
        for (int i = 0; i < 10; i++) tick();
        sys_done = 1'b1; sys_fail = 1'b1; sys_success = 1'b1;
        tick();
        sys_done = 1'b0; sys_fail = 1'b0; sys_success = 1'b0;
        checks++;
        if (status_fail !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || n_right != 0 || n_start != 1) begin
            failures++;
            $display("FAIL left_fail: fail=%b busy=%b in_ready=%b rights=%0d starts=%0d expected 1/0/0/0/1",
                     status_fail, busy, in_ready, n_right, n_start);
        end
        tick();
        do_abort();
        checks++;
        if (status_fail !== 1'b1 || status_success !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_keeps_status: fail=%b success=%b busy=%b expected 1/0/0",
                     status_fail, status_success, busy);
        end
    endtask

    task automatic test_timeout();
        do_start(2'b00, 2'b11);
        checks++;
        if (status_fail !== 1'b0) begin
            failures++;
            $display("FAIL fail_clear: status_fail=%b expected 0", status_fail);
        end
        do_load(DEPTH, 8'h40);
        checks++;
        if (sys_start !== 1'b1) begin
            failures++;
            $display("FAIL timeout_start: sys_start=%b expected 1", sys_start);
        end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (status_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: timeout=%b busy=%b at cycle 15 expected 0/1", status_timeout, busy);
        end
        tick();
        checks++;
        if (status_timeout !== 1'b1 || status_fail !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: timeout=%b fail=%b busy=%b at cycle 16 expected 1/1/0",
                     status_timeout, status_fail, busy);
        end
    endtask

    task automatic test_abort_load();
        do_start(2'b01, 2'b01);
        do_load(7, 8'h50);
        do_abort();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || status_timeout !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b in_ready=%b timeout=%b expected 0/0/0", busy, in_ready, status_timeout);
        end
        do_start(2'b01, 2'b01);
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 5'd0) begin
            failures++;
            $display("FAIL restart_addr: wr_en=%b addr=%0d expected 1/0", mem_wr_en, mem_wr_addr);
        end
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        checks++;
        if (mem[0] !== 8'h77) begin
            failures++;
            $display("FAIL restart_data: mem[0]=%h expected 77", mem[0]);
        end
        do_abort();
    endtask

    task automatic test_backpressure();
        int cycles;
        do_start(2'b11, 2'b11);
        do_load(DEPTH, 8'h60);
        sys_done = 1'b1; sys_success = 1'b1;
        tick();
        tick();
        sys_done = 1'b0; sys_success = 1'b0;
        run_unload(1'b1, cycles);
        checks++;
        if (status_success !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_end: success=%b busy=%b expected 1/0", status_success, busy);
        end
    endtask

    task automatic test_start_while_busy();
        n_start = 0;
        do_start(2'b01, 2'b10);
        do_load(DEPTH, 8'h80);
        cfg_left_op  = 2'b11;
        cfg_right_op = 2'b00;
        cmd_start    = 1'b1;
        tick();
        cmd_start    = 1'b0;
        tick();
        checks++;
        if (sys_left_op !== 2'b01 || sys_right_op !== 2'b10 || busy !== 1'b1 || n_start != 1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored: ops=%b/%b busy=%b starts=%0d in_ready=%b expected 01/10 1 1 0",
                     sys_left_op, sys_right_op, busy, n_start, in_ready);
        end
        do_abort();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_run: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        test_reset();
        test_full_pass();
        test_left_fail();
        test_timeout();
        test_abort_load();
        test_backpressure();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
